vga_out: RTL and testbench

Downstream display stage for the pixel processing unit: accepts processed pixel bytes over the same strobe/acknowledge byte handshake the processing unit drives, buffers them in a small FIFO, and scans them out with a parameterised VGA timing generator. It also emits the once-per-frame `sync` pulse that restarts the processing unit's pattern counters.

---
 rtl/vga_out.sv | 143 ++++++++++++++
 tb/tb_vga_out.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_out.sv
// Display output stage: byte handshake into a small pixel FIFO, scanned out by a
// parameterised VGA timing generator that also emits the once-per-frame sync pulse.
module vga_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIX_DIV    = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       stb_i,
  output logic       ack_i,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       de,
  output logic       sync,
  output logic       underflow
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          de_q, de_d, sync_q, sync_d, underflow_q, underflow_d;
  logic [5:0]    rgb_q, rgb_d;
  logic [5:0]    mem [FIFO_DEPTH];
  logic          tick, h_wrap, v_wrap, active, push, pop;

  // Only the colour bits are stored; the low two bits of each byte are don't-care.
  logic unused_data;
  assign unused_data = ^data_i[1:0];

  always_comb begin
    tick    = (div_q == DW'(PIX_DIV - 1));
    div_d   = tick ? '0 : div_q + 1'b1;
    h_wrap  = (h_cnt_q == HW'(H_TOTAL - 1));
    v_wrap  = (v_cnt_q == VW'(V_TOTAL - 1));
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end

    active = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    push   = ack_q & stb_i;
    // Pop sees only the registered count, so a same-clock push into an empty FIFO is not poppable.
    pop    = tick & active & (count_q != '0);
    ack_d  = stb_i & ~ack_q & (count_q < CW'(FIFO_DEPTH));

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    de_d        = de_q;
    rgb_d       = rgb_q;
    underflow_d = underflow_q;
    if (tick) begin
      hsync_d     = !((int'(h_cnt_q) >= HS_START) && (int'(h_cnt_q) < HS_END));
      vsync_d     = !((int'(v_cnt_q) >= VS_START) && (int'(v_cnt_q) < VS_END));
      de_d        = active;
      rgb_d       = pop ? mem[rd_ptr_q] : '0;
      underflow_d = underflow_q | (active & (count_q == '0));
    end
    sync_d = tick && (h_cnt_q == '0) && (int'(v_cnt_q) == V_ACTIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ack_q       <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      de_q        <= 1'b0;
      rgb_q       <= '0;
      sync_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ack_q       <= ack_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      rgb_q       <= rgb_d;
      sync_q      <= sync_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_i[7:2];
  end

  assign ack_i     = ack_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign r         = rgb_q[5:4];
  assign g         = rgb_q[3:2];
  assign b         = rgb_q[1:0];
  assign sync      = sync_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_vga_out.sv
// Directed bench for vga_out using a tiny 8x6 raster and a 4-entry FIFO.
module tb_vga_out;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       stb_i = 1'b0;
  logic       ack_i, hsync, vsync, de, sync, underflow;
  logic [1:0] r, g, b;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  vga_out #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_DIV(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .stb_i(stb_i), .ack_i(ack_i),
    .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b), .de(de),
    .sync(sync), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // cyc counts rising edges since reset release; outputs after edge k show raster position k-1.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stb_i = 1'b0;
    data_i = 8'h00;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic send_bytes(input logic [31:0] w, input int n);
    int idx;
    int budget;
    idx = 0;
    budget = 0;
    data_i = w[31:24];
    stb_i = 1'b1;
    while (idx < n && budget < 40) begin
      step();
      budget++;
      if (ack_i) begin
        step();
        idx++;
        if (idx < n) data_i = w[31-8*idx -: 8];
      end
    end
    stb_i = 1'b0;
    checks++;
    if (idx != n) begin
      failures++;
      $display("FAIL send_bytes: pushed %0d required %0d", idx, n);
    end
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    int h, v, nsync;
    rst = 1'b1;
    stb_i = 1'b0;
    step();
    step();
    checks++;
    if ({ack_i, hsync, vsync, r, g, b, de, sync, underflow} !== 12'b0_1_1_000000_0_0_0) begin
      failures++;
      $display("FAIL reset_hold: got %b required %b", {ack_i, hsync, vsync, r, g, b, de, sync, underflow}, 12'b0_1_1_000000_0_0_0);
    end
    rst = 1'b0;
    cyc = 0;
    checks++;
    if ({ack_i, hsync, vsync, r, g, b, de, sync, underflow} !== 12'b0_1_1_000000_0_0_0) begin
      failures++;
      $display("FAIL reset_release: got %b required %b", {ack_i, hsync, vsync, r, g, b, de, sync, underflow}, 12'b0_1_1_000000_0_0_0);
    end
    nsync = 0;
    for (int k = 1; k <= 48; k++) begin
      step();
      h = (k - 1) % 8;
      v = (k - 1) / 8;
      exp = {1'b0, !(h == 5 || h == 6), !(v == 4), 6'd0, (h < 4 && v < 3), (h == 0 && v == 3), 1'b1};
      if (sync) nsync++;
      checks++;
      if ({ack_i, hsync, vsync, r, g, b, de, sync, underflow} !== exp) begin
        failures++;
        $display("FAIL timing edge %0d: got %b required %b", k, {ack_i, hsync, vsync, r, g, b, de, sync, underflow}, exp);
      end
    end
    checks++;
    if (nsync != 1) begin
      failures++;
      $display("FAIL sync_count: got %0d required 1", nsync);
    end
  endtask

  task automatic test_handshake();
    logic exp_ack;
    do_reset();
    run_to(24);
    data_i = 8'hE4;
    stb_i = 1'b1;
    for (int k = 25; k <= 50; k++) begin
      step();
      exp_ack = (k <= 32) ? (k % 2 == 1) : (k == 50);
      checks++;
      if (ack_i !== exp_ack) begin
        failures++;
        $display("FAIL handshake_ack edge %0d: got %b required %b", k, ack_i, exp_ack);
      end
      if (k == 33) begin
        checks++;
        if (dut.count_q !== 3'd4) begin
          failures++;
          $display("FAIL fifo_full_count: got %0d required 4", dut.count_q);
        end
      end
      if (k == 49) begin
        checks++;
        if ({r, g, b, de} !== {2'd3, 2'd2, 2'd1, 1'b1}) begin
          failures++;
          $display("FAIL handshake_pixel: got %b required %b", {r, g, b, de}, {2'd3, 2'd2, 2'd1, 1'b1});
        end
      end
    end
    stb_i = 1'b0;
  endtask

  task automatic test_colour();
    logic [6:0] exp [8];
    exp[0] = {6'b111111, 1'b1};
    exp[1] = {6'b001100, 1'b1};
    exp[2] = {6'b000011, 1'b1};
    exp[3] = {6'b110000, 1'b1};
    for (int i = 4; i < 8; i++) exp[i] = 7'd0;
    do_reset();
    run_to(24);
    send_bytes(32'hFC300CC3, 4);
    run_to(48);
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({r, g, b, de} !== exp[i]) begin
        failures++;
        $display("FAIL colour pixel %0d: got %b required %b", i, {r, g, b, de}, exp[i]);
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow_init: got %b required 0", underflow);
    end
    step();
    checks++;
    if ({r, g, b, de, underflow} !== 8'b000000_1_1) begin
      failures++;
      $display("FAIL underflow_set: got %b required %b", {r, g, b, de, underflow}, 8'b000000_1_1);
    end
    run_to(24);
    send_bytes(32'hFC000000, 1);
    run_to(48);
    step();
    checks++;
    if ({r, g, b, de, underflow} !== 8'b111111_1_1) begin
      failures++;
      $display("FAIL underflow_sticky: got %b required %b", {r, g, b, de, underflow}, 8'b111111_1_1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_to(24);
    send_bytes(32'h54A80000, 2);
    run_to(47);
    data_i = 8'h90;
    stb_i = 1'b1;
    step();
    checks++;
    if (ack_i !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ack48: got %b required 1", ack_i);
    end
    step();
    data_i = 8'h24;
    checks++;
    if (dut.count_q !== 3'd2) begin
      failures++;
      $display("FAIL b2b_count: got %0d required 2", dut.count_q);
    end
    checks++;
    if ({r, g, b} !== 6'b010101) begin
      failures++;
      $display("FAIL b2b_pix0: got %b required %b", {r, g, b}, 6'b010101);
    end
    step();
    checks++;
    if ({r, g, b, ack_i} !== 7'b101010_1) begin
      failures++;
      $display("FAIL b2b_pix1: got %b required %b", {r, g, b, ack_i}, 7'b101010_1);
    end
    step();
    stb_i = 1'b0;
    checks++;
    if ({r, g, b} !== 6'b100100) begin
      failures++;
      $display("FAIL b2b_pix2: got %b required %b", {r, g, b}, 6'b100100);
    end
    step();
    checks++;
    if ({r, g, b} !== 6'b001001) begin
      failures++;
      $display("FAIL b2b_pix3: got %b required %b", {r, g, b}, 6'b001001);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    run_to(24);
    send_bytes(32'hFCFCFC00, 3);
    run_to(34);
    checks++;
    if (dut.count_q !== 3'd3 || vsync !== 1'b0 || underflow !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: count %0d vsync %b underflow %b required 3 0 1", dut.count_q, vsync, underflow);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ack_i, hsync, vsync, r, g, b, de, sync, underflow} !== 12'b0_1_1_000000_0_0_0) begin
      failures++;
      $display("FAIL midrst_outputs: got %b required %b", {ack_i, hsync, vsync, r, g, b, de, sync, underflow}, 12'b0_1_1_000000_0_0_0);
    end
    checks++;
    if (dut.count_q !== 3'd0) begin
      failures++;
      $display("FAIL midrst_count: got %0d required 0", dut.count_q);
    end
    step();
    rst = 1'b0;
    cyc = 0;
    step();
    checks++;
    if ({r, g, b, de, underflow} !== 8'b000000_1_1) begin
      failures++;
      $display("FAIL midrst_after: got %b required %b", {r, g, b, de, underflow}, 8'b000000_1_1);
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_colour();
    test_underflow();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
